// File: rtl/emc_slave.sv
// emc_slave: bridges the asynchronous EMC static-memory bus into single-clock
// register read/write strobes on the FPGA_CLK domain. Strobes are synchronized,
// address/data are pipelined to stay aligned with them, and each bus cycle
// produces exactly one reg_we_o or reg_re_o pulse.
module emc_slave #(
  parameter int AW          = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [AW-1:0] A,
  input  logic [15:0]   D_i,
  output logic [15:0]   D_o,
  output logic          D_oe,
  input  logic          WEN,
  input  logic          OEN,
  input  logic          CSN,
  output logic [AW-1:0] reg_adr_o,
  output logic [15:0]   reg_dat_o,
  output logic          reg_we_o,
  output logic          reg_re_o,
  input  logic [15:0]   reg_dat_i,
  output logic          err_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_HOLD = 2'd2
  } state_e;

  // Synchronizer chains (index 0 samples the pin) and edge-detect flops.
  logic [SYNC_STAGES-1:0] csn_sync_q, wen_sync_q, oen_sync_q;
  logic                   wen_p_q, oen_p_q;
  // Address/data pipeline of the same depth, plus one stage matching the edge flops.
  logic [AW-1:0]          a_pipe_q [SYNC_STAGES];
  logic [15:0]            d_pipe_q [SYNC_STAGES];
  logic [AW-1:0]          a_prev_q;
  logic [15:0]            d_prev_q;
  // Fills with ones after reset; edges count only once the edge flops hold real samples.
  logic [SYNC_STAGES:0]   vld_q;

  state_e        state_q;
  logic          rd_pend_q;
  logic [AW-1:0] rd_adr_q;
  logic [AW-1:0] reg_adr_q;
  logic [15:0]   reg_dat_q;
  logic          reg_we_q, reg_re_q;
  logic [15:0]   d_o_q;
  logic          d_oe_q;
  logic          err_q;

  logic          csn_s, wen_s, oen_s;
  logic [AW-1:0] a_s;
  logic          hist_ok, wen_rise, oen_fall, commit, rd_start;

  assign csn_s    = csn_sync_q[SYNC_STAGES-1];
  assign wen_s    = wen_sync_q[SYNC_STAGES-1];
  assign oen_s    = oen_sync_q[SYNC_STAGES-1];
  assign a_s      = a_pipe_q[SYNC_STAGES-1];
  assign hist_ok  = vld_q[SYNC_STAGES];
  assign wen_rise = hist_ok & wen_s & ~wen_p_q;
  assign oen_fall = hist_ok & ~oen_s & oen_p_q;
  assign commit   = wen_rise & ~csn_s;
  assign rd_start = oen_fall & ~csn_s;

  // Synchronize bus strobes and pipeline address/data alongside them.
  always_ff @(posedge clk_i) begin
    // NOTE: the small A/D pipeline arrays are reset explicitly so the first
    // post-reset sample compares against a defined idle bus, not X.
    if (!rst_n_i) begin
      csn_sync_q <= '1;
      wen_sync_q <= '1;
      oen_sync_q <= '1;
      wen_p_q    <= 1'b1;
      oen_p_q    <= 1'b1;
      vld_q      <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        a_pipe_q[i] <= '0;
        d_pipe_q[i] <= '0;
      end
      a_prev_q   <= '0;
      d_prev_q   <= '0;
    end else begin
      csn_sync_q <= {csn_sync_q[SYNC_STAGES-2:0], CSN};
      wen_sync_q <= {wen_sync_q[SYNC_STAGES-2:0], WEN};
      oen_sync_q <= {oen_sync_q[SYNC_STAGES-2:0], OEN};
      wen_p_q    <= wen_s;
      oen_p_q    <= oen_s;
      vld_q      <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      a_pipe_q[0] <= A;
      d_pipe_q[0] <= D_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        a_pipe_q[i] <= a_pipe_q[i-1];
        d_pipe_q[i] <= d_pipe_q[i-1];
      end
      a_prev_q   <= a_s;
      d_prev_q   <= d_pipe_q[SYNC_STAGES-1];
    end
  end

  // Strobe generation, read FSM and sticky error flag, all outputs registered.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments only; later assignments in this block
    // intentionally override earlier ones within the same clock.
    if (!rst_n_i) begin
      state_q   <= IDLE;
      rd_pend_q <= 1'b0;
      rd_adr_q  <= '0;
      reg_adr_q <= '0;
      reg_dat_q <= '0;
      reg_we_q  <= 1'b0;
      reg_re_q  <= 1'b0;
      d_o_q     <= '0;
      d_oe_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      reg_we_q <= commit;
      reg_re_q <= 1'b0;
      // Write data is the last aligned sample taken while WEN was still low.
      if (commit) begin
        reg_adr_q <= a_prev_q;
        reg_dat_q <= d_prev_q;
      end
      if (!csn_s && !wen_s && !oen_s) err_q <= 1'b1;
      if (commit && state_q != IDLE)  err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          // A write strobe owns reg_adr_o this clock; the read waits one more.
          if (rd_pend_q && !commit) begin
            state_q   <= RD_REQ;
            reg_re_q  <= 1'b1;
            reg_adr_q <= rd_adr_q;
            rd_pend_q <= 1'b0;
          end
        end
        RD_REQ: begin
          state_q <= RD_HOLD;
          d_o_q   <= reg_dat_i;
          d_oe_q  <= 1'b1;
        end
        RD_HOLD: begin
          if (oen_s || csn_s) begin
            state_q <= IDLE;
            d_oe_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (rd_start && state_q == IDLE) begin
        rd_pend_q <= 1'b1;
        rd_adr_q  <= a_s;
      end
    end
  end

  assign D_o       = d_o_q;
  assign D_oe      = d_oe_q;
  assign reg_adr_o = reg_adr_q;
  assign reg_dat_o = reg_dat_q;
  assign reg_we_o  = reg_we_q;
  assign reg_re_o  = reg_re_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_emc_slave.sv
// Directed testbench for emc_slave: write, read, paired writes, ignored and
// error cycles, reset in the middle of a read, and simultaneous strobes.
// Bus pins change 1 time unit after a rising edge; latencies count rising edges.
module tb_emc_slave;

  localparam int AW = 7;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] A = '0;
  logic [15:0]   D_i = '0;
  logic [15:0]   D_o;
  logic          D_oe;
  logic          WEN = 1'b1, OEN = 1'b1, CSN = 1'b1;
  logic [AW-1:0] reg_adr_o;
  logic [15:0]   reg_dat_o;
  logic          reg_we_o, reg_re_o;
  logic [15:0]   reg_dat_i = '0;
  logic          err_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] adr;
    logic [15:0]   dat;
  } ev_t;
  ev_t we_q[$];
  ev_t re_q[$];

  emc_slave #(.AW(AW), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .A(A), .D_i(D_i), .D_o(D_o), .D_oe(D_oe),
    .WEN(WEN), .OEN(OEN), .CSN(CSN), .reg_adr_o(reg_adr_o), .reg_dat_o(reg_dat_o),
    .reg_we_o(reg_we_o), .reg_re_o(reg_re_o), .reg_dat_i(reg_dat_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock; log any strobe seen after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (reg_we_o) we_q.push_back('{cyc, reg_adr_o, reg_dat_o});
    if (reg_re_o) re_q.push_back('{cyc, reg_adr_o, 16'h0});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_idle();
    CSN = 1'b1; WEN = 1'b1; OEN = 1'b1;
    steps(2 * S + 2);
    we_q.delete(); re_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    steps(3);
    chk_cnt++; if (D_oe !== 1'b0) $display("FAIL reset_doe: got %b want 0", D_oe); else pass_cnt++;
    chk_cnt++; if (D_o !== 16'h0) $display("FAIL reset_do: got %h want 0000", D_o); else pass_cnt++;
    chk_cnt++; if (reg_we_o !== 1'b0 || reg_re_o !== 1'b0)
      $display("FAIL reset_strobes: got we=%b re=%b want 0 0", reg_we_o, reg_re_o); else pass_cnt++;
    chk_cnt++; if (reg_adr_o !== '0 || reg_dat_o !== 16'h0)
      $display("FAIL reset_adr_dat: got %h/%h want 00/0000", reg_adr_o, reg_dat_o); else pass_cnt++;
    chk_cnt++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else pass_cnt++;
    rst_n = 1'b1;
    steps(2 * S + 2);
    chk_cnt++; if (we_q.size() != 0 || re_q.size() != 0)
      $display("FAIL reset_idle_strobes: got we=%0d re=%0d want 0 0", we_q.size(), re_q.size()); else pass_cnt++;
  endtask

  task automatic test_write();
    int t0;
    we_q.delete(); re_q.delete();
    CSN = 1'b0; A = 7'h01; D_i = 16'hfedc; WEN = 1'b0;
    steps(4);
    WEN = 1'b1; t0 = cyc;
    steps(8);
    chk_cnt++; if (we_q.size() != 1) $display("FAIL write_count: got %0d want 1", we_q.size()); else pass_cnt++;
    if (we_q.size() > 0) begin
      chk_cnt++; if (we_q[0].cyc - t0 != S + 1)
        $display("FAIL write_latency: got %0d want %0d", we_q[0].cyc - t0, S + 1); else pass_cnt++;
      chk_cnt++; if (we_q[0].adr !== 7'h01) $display("FAIL write_adr: got %h want 01", we_q[0].adr); else pass_cnt++;
      chk_cnt++; if (we_q[0].dat !== 16'hfedc) $display("FAIL write_dat: got %h want fedc", we_q[0].dat); else pass_cnt++;
    end
    chk_cnt++; if (re_q.size() != 0) $display("FAIL write_no_read: got %0d want 0", re_q.size()); else pass_cnt++;
    bus_idle();
  endtask

  task automatic test_read();
    int t0, oe_first, oe_last, dbad, re_cyc;
    we_q.delete(); re_q.delete();
    oe_first = -1; oe_last = -1; dbad = 0;
    reg_dat_i = 16'hdead;
    CSN = 1'b0; A = 7'h00; OEN = 1'b0; t0 = cyc;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (reg_re_o) reg_dat_i = 16'h0a10;
      if (D_oe) begin
        if (oe_first < 0) oe_first = cyc - t0;
        oe_last = cyc - t0;
        if (D_o !== 16'h0a10) dbad++;
      end
      if (i == 8) OEN = 1'b1;
    end
    re_cyc = (re_q.size() > 0) ? re_q[0].cyc - t0 : -1;
    chk_cnt++; if (re_q.size() != 1) $display("FAIL read_count: got %0d want 1", re_q.size()); else pass_cnt++;
    chk_cnt++; if (re_cyc != S + 2) $display("FAIL read_re_latency: got %0d want %0d", re_cyc, S + 2); else pass_cnt++;
    if (re_q.size() > 0) begin
      chk_cnt++; if (re_q[0].adr !== 7'h00) $display("FAIL read_adr: got %h want 00", re_q[0].adr); else pass_cnt++;
    end
    chk_cnt++; if (oe_first != S + 3) $display("FAIL read_oe_start: got %0d want %0d", oe_first, S + 3); else pass_cnt++;
    chk_cnt++; if (oe_last != 8 + S) $display("FAIL read_oe_end: got %0d want %0d", oe_last, 8 + S); else pass_cnt++;
    chk_cnt++; if (dbad != 0) $display("FAIL read_data: got %0d bad cycles want 0", dbad); else pass_cnt++;
    chk_cnt++; if (D_oe !== 1'b0 || D_o !== 16'h0a10)
      $display("FAIL read_after: got oe=%b do=%h want 0 0a10", D_oe, D_o); else pass_cnt++;
    chk_cnt++; if (we_q.size() != 0) $display("FAIL read_no_write: got %0d want 0", we_q.size()); else pass_cnt++;
    bus_idle();
  endtask

  task automatic test_back_to_back();
    we_q.delete(); re_q.delete();
    CSN = 1'b0; A = 7'h40; D_i = 16'h5678; WEN = 1'b0;
    steps(2);
    WEN = 1'b1;
    steps(2);
    A = 7'h41; D_i = 16'h1234; WEN = 1'b0;
    steps(2);
    WEN = 1'b1;
    steps(S + 4);
    chk_cnt++; if (we_q.size() != 2) $display("FAIL pair_count: got %0d want 2", we_q.size()); else pass_cnt++;
    if (we_q.size() == 2) begin
      chk_cnt++; if (we_q[0].adr !== 7'h40 || we_q[0].dat !== 16'h5678)
        $display("FAIL pair_first: got %h/%h want 40/5678", we_q[0].adr, we_q[0].dat); else pass_cnt++;
      chk_cnt++; if (we_q[1].adr !== 7'h41 || we_q[1].dat !== 16'h1234)
        $display("FAIL pair_second: got %h/%h want 41/1234", we_q[1].adr, we_q[1].dat); else pass_cnt++;
    end
    bus_idle();
  endtask

  task automatic test_ignored();
    we_q.delete(); re_q.delete();
    CSN = 1'b1; A = 7'h22; D_i = 16'h7777; WEN = 1'b0;
    steps(4);
    WEN = 1'b1;
    steps(8);
    chk_cnt++; if (we_q.size() != 0) $display("FAIL ignored_we: got %0d want 0", we_q.size()); else pass_cnt++;
    chk_cnt++; if (err_o !== 1'b0) $display("FAIL ignored_err: got %b want 0", err_o); else pass_cnt++;
    bus_idle();
  endtask

  task automatic test_simultaneous();
    int t0;
    CSN = 1'b0; A = 7'h0c; D_i = 16'h0bad; WEN = 1'b0; OEN = 1'b1;
    steps(4);
    we_q.delete(); re_q.delete();
    WEN = 1'b1; OEN = 1'b0; t0 = cyc;
    steps(8);
    chk_cnt++; if (we_q.size() != 1 || re_q.size() != 1)
      $display("FAIL simul_count: got we=%0d re=%0d want 1 1", we_q.size(), re_q.size()); else pass_cnt++;
    if (we_q.size() == 1 && re_q.size() == 1) begin
      chk_cnt++; if (we_q[0].cyc - t0 != S + 1)
        $display("FAIL simul_we_cyc: got %0d want %0d", we_q[0].cyc - t0, S + 1); else pass_cnt++;
      chk_cnt++; if (re_q[0].cyc - we_q[0].cyc != 1)
        $display("FAIL simul_re_after_we: got %0d want 1", re_q[0].cyc - we_q[0].cyc); else pass_cnt++;
      chk_cnt++; if (we_q[0].dat !== 16'h0bad || re_q[0].adr !== 7'h0c)
        $display("FAIL simul_values: got %h/%h want 0bad/0c", we_q[0].dat, re_q[0].adr); else pass_cnt++;
    end
    chk_cnt++; if (err_o !== 1'b0) $display("FAIL simul_err: got %b want 0", err_o); else pass_cnt++;
    bus_idle();
  endtask

  task automatic test_reset_mid_read();
    int n;
    CSN = 1'b0; A = 7'h05; reg_dat_i = 16'h1357; OEN = 1'b0;
    n = 0;
    while (D_oe !== 1'b1 && n < 20) begin step(); n++; end
    chk_cnt++; if (D_oe !== 1'b1) $display("FAIL midrst_reach_hold: got %b want 1", D_oe); else pass_cnt++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_cnt++; if (D_oe !== 1'b0 || D_o !== 16'h0)
      $display("FAIL midrst_outputs: got oe=%b do=%h want 0 0000", D_oe, D_o); else pass_cnt++;
    we_q.delete(); re_q.delete();
    steps(2 * S + 4);
    chk_cnt++; if (re_q.size() != 0 || D_oe !== 1'b0)
      $display("FAIL midrst_no_resume: got re=%0d oe=%b want 0 0", re_q.size(), D_oe); else pass_cnt++;
    bus_idle();
    CSN = 1'b0; A = 7'h06; reg_dat_i = 16'h2468; OEN = 1'b0;
    steps(S + 3);
    chk_cnt++; if (D_oe !== 1'b1 || D_o !== 16'h2468)
      $display("FAIL midrst_fresh_read: got oe=%b do=%h want 1 2468", D_oe, D_o); else pass_cnt++;
    chk_cnt++; if (re_q.size() != 1 || (re_q.size() == 1 && re_q[0].adr !== 7'h06))
      $display("FAIL midrst_fresh_re: got %0d strobes want 1 at adr 06", re_q.size()); else pass_cnt++;
    bus_idle();
  endtask

  task automatic test_error();
    CSN = 1'b0; A = 7'h03; WEN = 1'b0; OEN = 1'b0;
    steps(S + 3);
    chk_cnt++; if (err_o !== 1'b1) $display("FAIL err_set: got %b want 1", err_o); else pass_cnt++;
    CSN = 1'b1; WEN = 1'b1; OEN = 1'b1;
    steps(100);
    chk_cnt++; if (err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_o); else pass_cnt++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_cnt++; if (err_o !== 1'b0) $display("FAIL err_clear: got %b want 0", err_o); else pass_cnt++;
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_ignored();
    test_simultaneous();
    test_reset_mid_read();
    test_error();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
